// File: rtl/dcpu16_mem_arbiter.sv
// Shares the single DCPU16 RAM port between the CPU core and a device/DMA master.
// Fixed CPU priority with a starvation guard that forces a device win after MAX_WAIT denials.
module dcpu16_mem_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int RAM_LAT  = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dev_req,
    input  logic          dev_we,
    input  logic [AW-1:0] dev_addr,
    input  logic [DW-1:0] dev_wdata,
    output logic          dev_gnt,
    output logic          dev_rvalid,
    output logic [DW-1:0] dev_rdata,

    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    typedef enum logic {
        ST_NORMAL    = 1'b0,
        ST_FORCE_DEV = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_wait_cnt;
    logic [7:0]           w_wait_nxt;
    logic                 w_cpu_gnt;
    logic                 w_dev_gnt;
    logic                 w_rd_issue;
    logic [AW-1:0]        r_last_addr;
    logic [RAM_LAT-1:0]   r_pipe_vld;
    logic [RAM_LAT-1:0]   r_pipe_dev;

    // Grants are gated by rst_n so nothing is issued while reset is held.
    always_comb begin
        w_cpu_gnt   = 1'b0;
        w_dev_gnt   = 1'b0;
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;

        if (rst_n) begin
            case (r_state)
                ST_NORMAL: begin
                    w_cpu_gnt = cpu_req;
                    w_dev_gnt = dev_req & ~cpu_req;
                end
                ST_FORCE_DEV: begin
                    w_dev_gnt = dev_req;
                    w_cpu_gnt = cpu_req & ~dev_req;
                end
                default: begin
                    w_cpu_gnt = 1'b0;
                    w_dev_gnt = 1'b0;
                end
            endcase
        end

        if (!dev_req || w_dev_gnt) begin
            w_wait_nxt = 8'd0;
        end else if (r_wait_cnt < WAIT_MAX) begin
            w_wait_nxt = r_wait_cnt + 8'd1;
        end

        case (r_state)
            ST_NORMAL: begin
                if (w_wait_nxt == WAIT_MAX) begin
                    w_state_nxt = ST_FORCE_DEV;
                end
            end
            ST_FORCE_DEV: begin
                if (w_dev_gnt || !dev_req) begin
                    w_state_nxt = ST_NORMAL;
                end
            end
            default: w_state_nxt = ST_NORMAL;
        endcase
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign dev_gnt    = w_dev_gnt;
    assign w_rd_issue = (w_cpu_gnt & ~cpu_we) | (w_dev_gnt & ~dev_we);

    always_comb begin
        ram_addr = r_last_addr;
        ram_we   = 1'b0;
        ram_din  = '0;
        if (w_cpu_gnt) begin
            ram_addr = cpu_addr;
            ram_we   = cpu_we;
            ram_din  = cpu_wdata;
        end else if (w_dev_gnt) begin
            ram_addr = dev_addr;
            ram_we   = dev_we;
            ram_din  = dev_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_NORMAL;
            r_wait_cnt  <= 8'd0;
            r_last_addr <= '0;
            r_pipe_vld  <= '0;
            r_pipe_dev  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_cpu_gnt || w_dev_gnt) begin
                r_last_addr <= ram_addr;
            end
            // Return pipe tracks RAM latency; the tail stage lines up with ram_dout.
            r_pipe_vld[0] <= w_rd_issue;
            r_pipe_dev[0] <= w_dev_gnt;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_dev[i] <= r_pipe_dev[i-1];
            end
        end
    end

    assign cpu_rvalid = r_pipe_vld[RAM_LAT-1] & ~r_pipe_dev[RAM_LAT-1];
    assign dev_rvalid = r_pipe_vld[RAM_LAT-1] &  r_pipe_dev[RAM_LAT-1];
    assign cpu_rdata  = ram_dout;
    assign dev_rdata  = ram_dout;

endmodule

// File: tb/tb_dcpu16_mem_arbiter.sv
// Bench for dcpu16_mem_arbiter: directed scenarios plus randomized two-master traffic
// checked cycle by cycle against a behavioural arbiter/RAM model.
module tb_dcpu16_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int MW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dev_req, dev_we, dev_gnt, dev_rvalid;
    logic [AW-1:0] dev_addr;
    logic [DW-1:0] dev_wdata, dev_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    dcpu16_mem_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(LAT), .MAX_WAIT(MW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Synchronous RAM with LAT cycles of read latency and a preload port.
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] rd_pipe [0:LAT-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = rd_pipe[LAT-1];

    // Reference model state
    typedef struct {
        int            due;
        bit            dev;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] shadow [0:65535];
    rd_t           rq[$];
    int            denied;
    int            cyc;
    logic [AW-1:0] last_addr;
    logic          m_cg, m_dg;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic cr, input logic cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cwd,
                        input logic dr, input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
        logic          ecv, edv, ewe;
        logic [DW-1:0] ed, edin;
        logic [AW-1:0] ea;
        rd_t           e;
        @(negedge clk);
        cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
        dev_req = dr; dev_we = dwe; dev_addr = da; dev_wdata = dwd;
        #1;
        // CPU wins unless the device has already been refused MW cycles in a row.
        m_cg = cr && !(dr && denied >= MW);
        m_dg = dr && (!cr || denied >= MW);
        ea = last_addr; ewe = 1'b0; edin = '0;
        if (m_cg) begin ea = ca; ewe = cwe; edin = cwd; end
        else if (m_dg) begin ea = da; ewe = dwe; edin = dwd; end
        ecv = 1'b0; edv = 1'b0; ed = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e = rq.pop_front();
            ecv = !e.dev; edv = e.dev; ed = e.data;
        end
        chk("cpu_gnt", 32'(cpu_gnt), 32'(m_cg));
        chk("dev_gnt", 32'(dev_gnt), 32'(m_dg));
        chk("ram_addr", 32'(ram_addr), 32'(ea));
        chk("ram_we", 32'(ram_we), 32'(ewe));
        chk("ram_din", 32'(ram_din), 32'(edin));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ecv));
        chk("dev_rvalid", 32'(dev_rvalid), 32'(edv));
        if (ecv) chk("cpu_rdata", 32'(cpu_rdata), 32'(ed));
        if (edv) chk("dev_rdata", 32'(dev_rdata), 32'(ed));
        if (m_cg || m_dg) begin
            last_addr = ea;
            if (ewe) shadow[ea] = edin;
            else begin
                e.due = cyc + LAT; e.dev = m_dg; e.data = shadow[ea];
                rq.push_back(e);
            end
        end
        if (dr && !m_dg) begin
            if (denied < MW) denied++;
        end else begin
            denied = 0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // One-cycle reset pulse with both masters requesting; everything must stay quiet.
    task automatic do_reset();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h00AA; cpu_wdata = 16'h5555;
        dev_req = 1'b1; dev_we = 1'b0; dev_addr = 16'h00BB;
        rst_n = 1'b0;
        #1;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_dev_gnt", 32'(dev_gnt), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_rvalid", 32'({cpu_rvalid, dev_rvalid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cpu_req = 1'b0; dev_req = 1'b0;
        #1;
        chk("rel_rvalid", 32'({cpu_rvalid, dev_rvalid}), 32'd0);
        chk("rel_ram_addr", 32'(ram_addr), 32'd0);
        denied = 0; last_addr = '0; rq.delete(); cyc += 2;
    endtask

    logic          c_pend, c_we, d_pend, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wd, d_wd;
    int            k_found;
    logic [31:0]   pat;
    int            cpu_pct;

    initial begin
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dev_req = 1'b0; dev_we = 1'b0; dev_addr = '0; dev_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        denied = 0; cyc = 0; last_addr = '0;
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = 16'(a);
            pl_data = (a == 16) ? 16'h1234 : 16'($urandom);
            shadow[a] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
        do_reset();

        // Single CPU read returns the preloaded word after the RAM latency.
        step(1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
        idle(LAT);
        chk("t1_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("t1_rdata", 32'(cpu_rdata), 32'h1234);

        // Device write with CPU idle.
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 16'h8000, 16'hBEEF);
        chk("t2_ram_we", 32'(ram_we), 32'd1);
        chk("t2_ram_din", 32'(ram_din), 32'hBEEF);
        idle(1);
        chk("t2_mem", 32'(mem[16'h8000]), 32'hBEEF);
        idle(3);

        // Starvation guard: CPU hammering, device forced through after MW denials.
        k_found = -1;
        for (int k = 0; k < 20 && k_found < 0; k++) begin
            step(1'b1, 1'b0, 16'(k), '0, 1'b1, 1'b0, 16'h0020, '0);
            if (dev_gnt) k_found = k;
        end
        chk("t3_grant_cycle", 32'(k_found), 32'(MW));
        step(1'b1, 1'b0, 16'h0030, '0, 1'b1, 1'b0, 16'h0021, '0);
        chk("t3_back_normal", 32'(cpu_gnt), 32'd1);
        idle(4);

        // Back-to-back reads from alternating ports return in issue order.
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: step(1'b1, 1'b0, 16'h0001, '0, 1'b0, 1'b0, '0, '0);
                1: step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 16'h0002, '0);
                2: step(1'b1, 1'b0, 16'h0003, '0, 1'b0, 1'b0, '0, '0);
                default: idle(1);
            endcase
            pat = pat | (32'({cpu_rvalid, dev_rvalid}) << (2 * i));
        end
        chk("t4_order", pat, 32'h0000_0260);

        // Reset while a read is in flight drops it.
        step(1'b1, 1'b0, 16'h0010, '0, 1'b0, 1'b0, '0, '0);
        do_reset();
        idle(4);

        // Device backs off after 5 denials; a new request waits the full MW again.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 16'(k + 64), '0, 1'b1, 1'b0, 16'h0040, '0);
        step(1'b1, 1'b0, 16'h0045, '0, 1'b0, 1'b0, '0, '0);
        k_found = -1;
        for (int k = 0; k < 20 && k_found < 0; k++) begin
            step(1'b1, 1'b0, 16'(k + 80), '0, 1'b1, 1'b0, 16'h0041, '0);
            if (dev_gnt) k_found = k;
        end
        chk("t6_regrant", 32'(k_found), 32'(MW));
        idle(4);

        // Randomized traffic with requesters that hold their fields until granted.
        c_pend = 1'b0; d_pend = 1'b0;
        c_we = 1'b0; d_we = 1'b0; c_addr = '0; d_addr = '0; c_wd = '0; d_wd = '0;
        for (int ph = 0; ph < 3; ph++) begin
            cpu_pct = (ph == 0) ? 95 : (ph == 1) ? 50 : 20;
            for (int i = 0; i < 600; i++) begin
                if (!c_pend && $urandom_range(0, 99) < cpu_pct) begin
                    c_pend = 1'b1; c_we = ($urandom_range(0, 99) < 30);
                    c_addr = 16'($urandom_range(0, 255)); c_wd = 16'($urandom);
                end
                if (!d_pend && $urandom_range(0, 99) < 70) begin
                    d_pend = 1'b1; d_we = ($urandom_range(0, 99) < 30);
                    d_addr = 16'($urandom_range(0, 255)); d_wd = 16'($urandom);
                end
                step(c_pend, c_we, c_addr, c_wd, d_pend, d_we, d_addr, d_wd);
                if (m_cg) c_pend = 1'b0;
                if (m_dg) d_pend = 1'b0;
                if (ph == 1 && i == 300) begin
                    do_reset();
                    c_pend = 1'b0; d_pend = 1'b0;
                end
            end
        end
        idle(LAT + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
